// File: rtl/sample_walk_ctrl.sv
// sample_walk_ctrl: captures one micropolygon and its bounding box, then walks
// every sample position in the box on the selected subsample grid, one sample
// per accepted cycle, row-major with x fastest. Upstream is stalled with
// halt_out for the whole walk; downstream stalls the walk with halt_in.
module sample_walk_ctrl #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_in,
   input  logic [COLORS*SIGFIG-1:0]        color_in,
   input  logic [4*SIGFIG-1:0]             box_in,
   input  logic                            valid_in,
   output logic                            halt_out,
   input  logic [3:0]                      subsample_step,
   output logic [VERTS*AXIS*SIGFIG-1:0]    tri_out,
   output logic [COLORS*SIGFIG-1:0]        color_out,
   output logic [2*SIGFIG-1:0]             sample_out,
   output logic                            valid_out,
   input  logic                            halt_in
);

   localparam int TW = VERTS*AXIS*SIGFIG;
   localparam int CW = COLORS*SIGFIG;

   typedef enum logic {WAIT, WALK} state_t;

   state_t                    state_reg, state_next;
   logic [TW-1:0]             tri_reg, tri_next;
   logic [CW-1:0]             color_reg, color_next;
   logic signed [SIGFIG-1:0]  ll_x_reg, ll_x_next;
   logic signed [SIGFIG-1:0]  ll_y_reg, ll_y_next;
   logic signed [SIGFIG-1:0]  ur_x_reg, ur_x_next;
   logic signed [SIGFIG-1:0]  ur_y_reg, ur_y_next;
   logic signed [SIGFIG-1:0]  x_reg, x_next;
   logic signed [SIGFIG-1:0]  y_reg, y_next;
   logic signed [SIGFIG:0]    step_reg, step_next;
   logic                      valid_reg, valid_next;

   // Incoming box corners, unpacked from {ur_y, ur_x, ll_y, ll_x}
   logic signed [SIGFIG-1:0]  box_ll_x, box_ll_y, box_ur_x, box_ur_y;
   assign box_ll_x = box_in[SIGFIG-1:0];
   assign box_ll_y = box_in[2*SIGFIG-1:SIGFIG];
   assign box_ur_x = box_in[3*SIGFIG-1:2*SIGFIG];
   assign box_ur_y = box_in[4*SIGFIG-1:3*SIGFIG];

   logic box_empty;
   assign box_empty = (box_ur_x < box_ll_x) || (box_ur_y < box_ll_y);

   // Candidate step sizes, one per select bit: 1 << (RADIX-3+i)
   logic [3:0][SIGFIG:0] step_opt;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_step_opt
         assign step_opt[gi] = (SIGFIG+1)'(1) << (RADIX - 3 + gi);
      end
   endgenerate

   logic step_one_hot;
   assign step_one_hot = (subsample_step != 4'd0) &&
                         ((subsample_step & (subsample_step - 4'd1)) == 4'd0);

   // Decode the step select; anything not one-hot falls back to one pixel
   logic signed [SIGFIG:0] step_dec;
   always_comb begin
      step_dec = (SIGFIG+1)'(1) << RADIX;
      if (step_one_hot) begin
         for (int i = 0; i < 4; i++) begin
            if (subsample_step[i]) step_dec = step_opt[i];
         end
      end
   end

   // Next positions in one extra bit so a step past the top of the range
   // cannot wrap around and look like it is still inside the box
   logic signed [SIGFIG:0] nx, ny, ur_x_ext, ur_y_ext;
   assign nx       = {x_reg[SIGFIG-1], x_reg} + step_reg;
   assign ny       = {y_reg[SIGFIG-1], y_reg} + step_reg;
   assign ur_x_ext = {ur_x_reg[SIGFIG-1], ur_x_reg};
   assign ur_y_ext = {ur_y_reg[SIGFIG-1], ur_y_reg};

   // Next-state and datapath update for capture and walk
   always_comb begin
      state_next = state_reg;
      tri_next   = tri_reg;
      color_next = color_reg;
      ll_x_next  = ll_x_reg;
      ll_y_next  = ll_y_reg;
      ur_x_next  = ur_x_reg;
      ur_y_next  = ur_y_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      step_next  = step_reg;
      valid_next = valid_reg;
      case (state_reg)
         WAIT: begin
            if (valid_in) begin
               tri_next   = tri_in;
               color_next = color_in;
               ll_x_next  = box_ll_x;
               ll_y_next  = box_ll_y;
               ur_x_next  = box_ur_x;
               ur_y_next  = box_ur_y;
               step_next  = step_dec;
               // An empty box is consumed here without producing samples
               if (!box_empty) begin
                  x_next     = box_ll_x;
                  y_next     = box_ll_y;
                  valid_next = 1'b1;
                  state_next = WALK;
               end
            end
         end
         WALK: begin
            if (!halt_in) begin
               if (nx <= ur_x_ext) begin
                  x_next = nx[SIGFIG-1:0];
               end else if (ny <= ur_y_ext) begin
                  x_next = ll_x_reg;
                  y_next = ny[SIGFIG-1:0];
               end else begin
                  valid_next = 1'b0;
                  state_next = WAIT;
               end
            end
         end
         default: begin
            valid_next = 1'b0;
            state_next = WAIT;
         end
      endcase
   end

   // State and datapath registers; reset abandons any walk in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= WAIT;
         tri_reg   <= '0;
         color_reg <= '0;
         ll_x_reg  <= '0;
         ll_y_reg  <= '0;
         ur_x_reg  <= '0;
         ur_y_reg  <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         step_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         tri_reg   <= tri_next;
         color_reg <= color_next;
         ll_x_reg  <= ll_x_next;
         ll_y_reg  <= ll_y_next;
         ur_x_reg  <= ur_x_next;
         ur_y_reg  <= ur_y_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         step_reg  <= step_next;
         valid_reg <= valid_next;
      end
   end

   assign halt_out   = (state_reg == WALK);
   assign valid_out  = valid_reg;
   assign sample_out = {y_reg, x_reg};
   assign tri_out    = tri_reg;
   assign color_out  = color_reg;

endmodule

// File: tb/tb_sample_walk_ctrl.sv
// Bench for sample_walk_ctrl: a queue-based model of the expected sample
// stream checked every cycle, plus literal expectations per directed case.
module tb_sample_walk_ctrl;

   localparam int S  = 24;
   localparam int TW = 216;
   localparam int CW = 72;

   logic            clk = 1'b0;
   logic            rst;
   logic [TW-1:0]   tri_in;
   logic [CW-1:0]   color_in;
   logic [4*S-1:0]  box_in;
   logic            valid_in;
   logic            halt_out;
   logic [3:0]      subsample_step;
   logic [TW-1:0]   tri_out;
   logic [CW-1:0]   color_out;
   logic [2*S-1:0]  sample_out;
   logic            valid_out;
   logic            halt_in;

   sample_walk_ctrl dut (
      .clk(clk), .rst(rst), .tri_in(tri_in), .color_in(color_in),
      .box_in(box_in), .valid_in(valid_in), .halt_out(halt_out),
      .subsample_step(subsample_step), .tri_out(tri_out),
      .color_out(color_out), .sample_out(sample_out),
      .valid_out(valid_out), .halt_in(halt_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [2*S-1:0] pk(input int x, input int y);
      logic [31:0] xv, yv;
      xv = x;
      yv = y;
      return {yv[S-1:0], xv[S-1:0]};
   endfunction

   function automatic int dec_step(input logic [3:0] s);
      if ($countones(s) == 1) begin
         for (int i = 0; i < 4; i++) if (s[i]) return 1 << (7 + i);
      end
      return 1024;
   endfunction

   function automatic int sx(input logic [S-1:0] v);
      return int'(signed'(v));
   endfunction

   // ---------------- behavioural model ----------------
   logic [2*S-1:0] exp_q[$];
   logic [TW-1:0]  exp_tri;
   logic [CW-1:0]  exp_col;
   bit             started = 0;
   bit             just_rst = 0;

   // Model update at each edge from the inputs, then compare outputs 1 ns later
   always @(posedge clk) begin
      just_rst = 0;
      if (rst) begin
         exp_q.delete();
         exp_tri  = '0;
         exp_col  = '0;
         started  = 1;
         just_rst = 1;
      end else if (started) begin
         if (exp_q.size() > 0) begin
            if (!halt_in) void'(exp_q.pop_front());
         end else if (valid_in) begin
            int llx, lly, urx, ury, st;
            llx = sx(box_in[S-1:0]);
            lly = sx(box_in[2*S-1:S]);
            urx = sx(box_in[3*S-1:2*S]);
            ury = sx(box_in[4*S-1:3*S]);
            st  = dec_step(subsample_step);
            exp_tri = tri_in;
            exp_col = color_in;
            for (longint y = lly; y <= ury; y += st)
               for (longint x = llx; x <= urx; x += st)
                  exp_q.push_back(pk(int'(x), int'(y)));
         end
      end
      #1;
      if (started) begin
         chk("valid_out", 256'(valid_out), 256'(exp_q.size() > 0));
         chk("halt_out", 256'(halt_out), 256'(exp_q.size() > 0));
         if (just_rst) begin
            chk("rst_sample", 256'(sample_out), 256'(0));
            chk("rst_tri", 256'(tri_out), 256'(0));
            chk("rst_color", 256'(color_out), 256'(0));
         end
         if (exp_q.size() > 0) begin
            chk("sample_out", 256'(sample_out), 256'(exp_q[0]));
            chk("tri_out", 256'(tri_out), 256'(exp_tri));
            chk("color_out", 256'(color_out), 256'(exp_col));
         end
      end
   end

   // Log of samples accepted by downstream and count of stalled-upstream cycles
   logic [2*S-1:0] log_q[$];
   int halt_cnt = 0;

   always @(posedge clk) begin
      if (!rst && valid_out === 1'b1 && !halt_in) begin
         log_q.push_back(sample_out);
         $display("accept x=%0d y=%0d", sx(sample_out[S-1:0]), sx(sample_out[2*S-1:S]));
      end
   end

   always @(negedge clk) if (halt_out === 1'b1) halt_cnt++;

   // ---------------- stimulus helpers ----------------
   task automatic setup(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] st, input logic [7:0] id);
      logic [31:0] a, b, c, d;
      a = llx; b = lly; c = urx; d = ury;
      box_in         = {d[S-1:0], c[S-1:0], b[S-1:0], a[S-1:0]};
      subsample_step = st;
      tri_in         = {27{id}};
      color_in       = {9{id ^ 8'h5a}};
      valid_in       = 1'b1;
   endtask

   // Called just after a negedge; holds valid_in for one cycle
   task automatic present(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] st, input logic [7:0] id);
      setup(llx, lly, urx, ury, st, id);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!halt_out && !valid_out) return;
         @(negedge clk);
      end
      chk("wait_idle_timeout", 256'(1), 256'(0));
   endtask

   task automatic chk_log(input string name, input logic [2*S-1:0] exp[$]);
      chk({name, "_count"}, 256'(log_q.size()), 256'(exp.size()));
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         chk({name, "_sample"}, 256'(log_q[i]), 256'(exp[i]));
   endtask

   task automatic begin_test();
      log_q.delete();
      halt_cnt = 0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [2*S-1:0] e[$];
      rst = 1'b1; valid_in = 1'b0; halt_in = 1'b0;
      subsample_step = 4'b0000; box_in = '0; tri_in = '0; color_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 256'(valid_out), 256'(0));
      chk("reset_halt", 256'(halt_out), 256'(0));
      chk("reset_sample", 256'(sample_out), 256'(0));
      chk("reset_tri", 256'(tri_out), 256'(0));
      rst = 1'b0;
      @(negedge clk);

      // Basic 3x3 walk; step select changed mid-walk must not matter
      begin_test();
      present(1024, 2048, 2048, 3072, 4'b0100, 8'h11);
      subsample_step = 4'b0001;
      wait_idle();
      e = '{pk(1024,2048), pk(1536,2048), pk(2048,2048),
            pk(1024,2560), pk(1536,2560), pk(2048,2560),
            pk(1024,3072), pk(1536,3072), pk(2048,3072)};
      chk_log("basic", e);
      chk("basic_halt_cycles", 256'(halt_cnt), 256'(9));
      @(negedge clk);

      // Degenerate box, then a second polygon held back-to-back
      begin_test();
      present(0, 0, 0, 0, 4'b1000, 8'h22);
      setup(0, 0, 1024, 0, 4'b1000, 8'h33);
      @(negedge clk);
      chk("bubble_valid", 256'(valid_out), 256'(0));
      chk("bubble_halt", 256'(halt_out), 256'(0));
      @(negedge clk);
      valid_in = 1'b0;
      chk("second_first_valid", 256'(valid_out), 256'(1));
      wait_idle();
      e = '{pk(0,0), pk(0,0), pk(1024,0)};
      chk_log("degen", e);
      chk("degen_halt_cycles", 256'(halt_cnt), 256'(3));
      @(negedge clk);

      // Backpressure on sample (1536,2560) for 3 cycles
      begin_test();
      present(1024, 2048, 2048, 3072, 4'b0100, 8'h44);
      repeat (4) @(negedge clk);
      chk("bp_held_sample", 256'(sample_out), 256'(pk(1536,2560)));
      halt_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("bp_still_held", 256'(sample_out), 256'(pk(1536,2560)));
      halt_in = 1'b0;
      wait_idle();
      e = '{pk(1024,2048), pk(1536,2048), pk(2048,2048),
            pk(1024,2560), pk(1536,2560), pk(2048,2560),
            pk(1024,3072), pk(1536,3072), pk(2048,3072)};
      chk_log("bp", e);
      chk("bp_halt_cycles", 256'(halt_cnt), 256'(12));
      @(negedge clk);

      // Negative coordinates with a non-one-hot step
      begin_test();
      present(-1024, -1024, 0, -1024, 4'b0000, 8'h55);
      wait_idle();
      e = '{pk(-1024,-1024), pk(0,-1024)};
      chk_log("neg", e);
      chk("neg_halt_cycles", 256'(halt_cnt), 256'(2));
      @(negedge clk);

      // Empty box is consumed silently
      begin_test();
      present(2048, 0, 1024, 0, 4'b0100, 8'h66);
      repeat (3) @(negedge clk);
      e.delete();
      chk_log("empty", e);
      chk("empty_halt_cycles", 256'(halt_cnt), 256'(0));

      // Reset on the 4th sample of the basic walk, then a fresh polygon
      begin_test();
      present(1024, 2048, 2048, 3072, 4'b0100, 8'h77);
      repeat (3) @(negedge clk);
      chk("pre_rst_sample", 256'(sample_out), 256'(pk(1024,2560)));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_valid", 256'(valid_out), 256'(0));
      chk("post_rst_halt", 256'(halt_out), 256'(0));
      e = '{pk(1024,2048), pk(1536,2048), pk(2048,2048)};
      chk_log("rst_partial", e);
      begin_test();
      present(3072, 1024, 3584, 1024, 4'b0100, 8'h88);
      wait_idle();
      e = '{pk(3072,1024), pk(3584,1024)};
      chk_log("after_rst", e);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sample_walk_ctrl.md
Name: sample_walk_ctrl

Overview:
- Sequencer between the bounding-box stage and the sample-test/hash stages of the rasterizer.
- Accepts one micropolygon and its bounding box per transaction.
- Walks every sample position inside the box on the selected subsample grid, one sample per accepted cycle, in row-major order with x fastest.
- Stalls the bbox stage with halt_out for the whole walk, and obeys downstream backpressure through halt_in.

Parameters:
SIGFIG, 24, bits per fixed-point coordinate/color, signed two's complement
RADIX, 10, fraction bits; one pixel = 1<<RADIX
VERTS, 3, vertices per micropolygon
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
tri_in  in  VERTS*AXIS*SIGFIG  vertex data (216 at defaults)
color_in  in  COLORS*SIGFIG  polygon color (72)
box_in  in  4*SIGFIG  {ur_y, ur_x, ll_y, ll_x}, LSB = ll_x (96)
valid_in  in  1  upstream transaction valid
halt_out  out  1  1 = block cannot accept; upstream holds its data
subsample_step  in  4  one-hot step select: [3]=1024, [2]=512, [1]=256, [0]=128 (i.e. 1<<(RADIX-3+i))
tri_out  out  VERTS*AXIS*SIGFIG  captured vertex data
color_out  out  COLORS*SIGFIG  captured color
sample_out  out  2*SIGFIG  {y, x} current sample position
valid_out  out  1  sample_out/tri_out/color_out valid
halt_in  in  1  downstream stall; 1 = hold current sample

Behaviour:
- FSM has two states, WAIT and WALK.

Reset:
- state = WAIT, valid_out = 0, sample_out = 0, tri_out = 0, color_out = 0.
- halt_out = 0 in the cycle after rst.
- rst asserted mid-walk abandons the polygon, with no further samples.

halt_out:
- Combinational from state: 0 in WAIT, 1 in WALK.

Step decoding:
- The step is latched at capture; later changes to subsample_step do not affect a walk in progress.
- A non-one-hot subsample_step (zero or multiple bits set) selects step = 1<<RADIX.

WAIT:
- If valid_in = 1, latch tri_in, color_in, box_in and the decoded step.
- If ur_x < ll_x or ur_y < ll_y (signed compare), the box is empty. The transaction is consumed, zero samples are emitted and the FSM stays in WAIT.
- Otherwise sample = (ll_x, ll_y), valid_out = 1 next cycle, and the FSM goes to WALK.
- Latency: capture edge to first valid sample is 1 cycle.

WALK:
- valid_out = 1. All outputs are held stable while halt_in = 1; no sample is skipped or duplicated.
- When halt_in = 0, the current sample is accepted at the edge and the FSM advances:
  - nx = x + step, computed in SIGFIG+1 bits signed; no wrap.
  - If nx <= ur_x: x = nx.
  - Else, with ny = y + step: if ny <= ur_y then x = ll_x, y = ny; else the walk is done.
- Done: state = WAIT, valid_out = 0 next cycle. A new polygon is captured at the earliest one cycle after the last sample is accepted, giving a one-cycle bubble between polygons.

Box alignment:
- Box corners arrive already aligned to the step grid. The block does not snap them.
- Samples are ll + k*step, never exceeding ur.
- A degenerate box (ll == ur) yields exactly one sample.

Throughput and ordering:
- Throughput is 1 sample/cycle with halt_in = 0.
- Samples per polygon = ((ur_x-ll_x)/step+1) * ((ur_y-ll_y)/step+1).

Test Plan:
- Basic 3x3 walk: box ll=(1024,2048), ur=(2048,3072), step one-hot 0100 (512), halt_in = 0 -> 9 consecutive valid samples. x cycles 1024,1536,2048 within each row; y runs 2048,2560,3072. halt_out is high for 9 cycles, then valid_out = 0.
- Degenerate box: ll = ur = (0,0), step 1000 -> exactly one sample (0,0). halt_out is high for 1 cycle. A second polygon presented back-to-back is captured after the one-cycle bubble.
- Backpressure: same box as the basic walk; halt_in = 1 for 3 cycles while sample (1536,2560) is shown -> sample_out stays fixed. The sequence still contains 9 unique samples in order, and total walk = 12 cycles.
- Negative coordinates and invalid step: ll=(-1024,-1024), ur=(0,-1024), subsample_step = 0000 -> step 1024, samples (-1024,-1024) then (0,-1024), then done.
- Empty box: ll=(2048,0), ur=(1024,0) with valid_in = 1 -> transaction consumed, valid_out never rises, halt_out stays 0.
- Reset mid-walk: assert rst on the 4th sample of the basic 3x3 walk -> next cycle valid_out = 0, halt_out = 0. A new polygon is then walked from its own ll corner with no stale samples.
